// File: rtl/temp_disp_pkg.sv
// Shared glyphs, field layout and index type for the temperature display scanner.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package temp_disp_pkg;

  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_F     = 7'b0001110;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;

  // Element n of the packed array is the glyph for digit n.
  localparam logic [9:0][6:0] GLYPH_DIGIT = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef struct packed {
    logic [3:0] thou;
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       sign;
    logic       c_f;
  } disp_fields_t;

  typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/temp_display_scan_seg7_decode.sv
// BCD to active-low seven-segment glyph; codes above 9 render as 'E' even when blank is requested.
module seg7_decode
  import temp_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] segs_n
);

  always_comb begin
    if (bcd > 4'd9)
      segs_n = GLYPH_E;
    else if (blank)
      segs_n = GLYPH_BLANK;
    else
      segs_n = GLYPH_DIGIT[bcd];
  end

endmodule

// File: rtl/temp_display_scan.sv
// 8-digit multiplexed display of a signed temperature (x10, BCD) with C/F suffix.
// Inputs are shadowed and promoted to the display only at frame boundaries, so a frame never tears.
module temp_display_scan
  import temp_disp_pkg::*;
#(
  parameter int DIV_COUNT    = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd,
  input  logic [3:0] thou,
  input  logic [3:0] hund,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       sign,
  input  logic       c_f,
  output logic [7:0] an_n,
  output logic [6:0] segs_n,
  output logic       dp_n
);

  localparam int PW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;

  logic [PW-1:0] presc;
  digit_idx_t    idx;
  disp_fields_t  in_fields;
  disp_fields_t  shadow;
  disp_fields_t  disp;
  logic          pend;
  logic          wrap;
  logic          boundary;

  logic [3:0]    dec_bcd;
  logic          dec_blank;
  logic [6:0]    dec_segs;
  logic [7:0]    slot_an;
  logic [6:0]    slot_segs;
  logic          slot_dp;

  assign in_fields = {thou, hund, tens, ones, sign, c_f};
  assign wrap      = (presc == PW'(DIV_COUNT - 1));
  assign boundary  = wrap && (idx == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= wrap ? '0 : presc + 1'b1;
      if (wrap)
        idx <= idx + 3'd1;
    end
  end

  // An upd coinciding with the boundary lands in the shadow and waits a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      disp   <= '0;
      pend   <= 1'b0;
    end else begin
      if (boundary && pend)
        disp <= shadow;
      if (upd) begin
        shadow <= in_fields;
        pend   <= 1'b1;
      end else if (boundary) begin
        pend   <= 1'b0;
      end
    end
  end

  always_comb begin
    dec_bcd   = 4'd0;
    dec_blank = 1'b1;
    case (idx)
      3'd1: begin dec_bcd = disp.ones; dec_blank = 1'b0; end
      3'd2: begin dec_bcd = disp.tens; dec_blank = 1'b0; end
      3'd3: begin dec_bcd = disp.hund; dec_blank = (disp.hund == 4'd0) && (disp.thou == 4'd0); end
      3'd4: begin dec_bcd = disp.thou; dec_blank = (disp.thou == 4'd0); end
      default: ;
    endcase
  end

  seg7_decode u_dec (
    .bcd    (dec_bcd),
    .blank  (dec_blank),
    .segs_n (dec_segs)
  );

  always_comb begin
    slot_segs = GLYPH_BLANK;
    case (idx)
      3'd0:                   slot_segs = disp.c_f ? GLYPH_F : GLYPH_C;
      3'd1, 3'd2, 3'd3, 3'd4: slot_segs = dec_segs;
      3'd5:                   slot_segs = disp.sign ? GLYPH_MINUS : GLYPH_BLANK;
      default:                slot_segs = GLYPH_BLANK;
    endcase
    slot_dp = (idx != 3'd2);
    slot_an = (presc < PW'(BLANK_CYCLES)) ? 8'hFF : ~(8'h01 << idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n   <= 8'hFF;
      segs_n <= GLYPH_BLANK;
      dp_n   <= 1'b1;
    end else begin
      an_n   <= slot_an;
      segs_n <= slot_segs;
      dp_n   <= slot_dp;
    end
  end

endmodule

// File: tb/tb_temp_display_scan.sv
// Randomized and directed stimulus against a cycle-count reference of the scanned display.
module tb_temp_display_scan;

  localparam int DIV   = 4;
  localparam int BLK   = 1;
  localparam int FRAME = DIV * 8;

  logic       clk;
  logic       rst_n;
  logic       upd;
  logic [3:0] thou, hund, tens, ones;
  logic       sign, c_f;
  logic [7:0] an_n;
  logic [6:0] segs_n;
  logic       dp_n;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  temp_display_scan #(.DIV_COUNT(DIV), .BLANK_CYCLES(BLK)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .upd    (upd),
    .thou   (thou),
    .hund   (hund),
    .tens   (tens),
    .ones   (ones),
    .sign   (sign),
    .c_f    (c_f),
    .an_n   (an_n),
    .segs_n (segs_n),
    .dp_n   (dp_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: cycles since reset release; digits index 0=thou,1=hund,2=tens,3=ones
  int         mn = 0;
  logic [3:0] md [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic       m_sign = 1'b0, m_cf = 1'b0;
  logic [3:0] sd [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic       s_sign = 1'b0, s_cf = 1'b0;
  logic       m_pend = 1'b0;
  logic [7:0] e_an = 8'hFF;
  logic [6:0] e_sg = 7'h7F;
  logic       e_dp = 1'b1;

  logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [6:0] glyph(input logic [3:0] d);
    return (d > 4'd9) ? 7'b0000110 : tbl[d];
  endfunction

  task automatic render(input int n, output logic [7:0] an, output logic [6:0] sg, output logic dp);
    int slot, p;
    slot = (n / DIV) % 8;
    p    = n % DIV;
    an   = (p < BLK) ? 8'hFF : ~(8'h01 << slot);
    dp   = (slot == 2) ? 1'b0 : 1'b1;
    case (slot)
      0: sg = m_cf ? 7'b0001110 : 7'b1000110;
      1: sg = glyph(md[3]);
      2: sg = glyph(md[2]);
      3: sg = (md[1] == 0 && md[0] == 0) ? 7'h7F : glyph(md[1]);
      4: sg = (md[0] == 0) ? 7'h7F : glyph(md[0]);
      5: sg = m_sign ? 7'b0111111 : 7'h7F;
      default: sg = 7'h7F;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mn = 0; m_pend = 0;
      md = '{4'd0, 4'd0, 4'd0, 4'd0}; sd = '{4'd0, 4'd0, 4'd0, 4'd0};
      m_sign = 0; m_cf = 0; s_sign = 0; s_cf = 0;
      e_an = 8'hFF; e_sg = 7'h7F; e_dp = 1'b1;
    end else begin
      render(mn, e_an, e_sg, e_dp);
      if ((mn % FRAME) == FRAME - 1 && m_pend) begin
        md = sd; m_sign = s_sign; m_cf = s_cf; m_pend = 0;
      end
      if (upd) begin
        sd = '{thou, hund, tens, ones}; s_sign = sign; s_cf = c_f; m_pend = 1;
      end
      mn++;
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("an_n", an_n, e_an);
      if (e_an != 8'hFF) begin
        check("segs_n", {1'b0, segs_n}, {1'b0, e_sg});
        check("dp_n", {7'd0, dp_n}, {7'd0, e_dp});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] t, input logic [3:0] h, input logic [3:0] te,
                      input logic [3:0] o, input logic s, input logic c);
    thou = t; hund = h; tens = te; ones = o; sign = s; c_f = c; upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  task automatic align(input int r);
    for (int k = 0; k < 2 * FRAME && (mn % FRAME) != r; k++) tick();
  endtask

  initial begin
    rst_n = 1'b0; upd = 1'b0;
    thou = 0; hund = 0; tens = 0; ones = 0; sign = 0; c_f = 0;
    chk_en = 1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (40) tick();

    repeat (10) tick();
    send(4'd0, 4'd2, 4'd5, 4'd3, 1'b0, 1'b0);
    repeat (70) tick();

    send(4'd1, 4'd0, 4'd4, 4'd7, 1'b1, 1'b1);
    repeat (70) tick();

    align(5);
    send(4'd0, 4'd1, 4'd2, 4'd0, 1'b0, 1'b0);
    repeat (6) tick();
    send(4'd0, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0);
    repeat (70) tick();

    align(FRAME - 1);
    send(4'd0, 4'd0, 4'hC, 4'd5, 1'b0, 1'b0);
    repeat (70) tick();

    // Asynchronous reset in the middle of slot d4
    align(4 * DIV + 2);
    rst_n = 1'b0;
    #1;
    check("rst_an", an_n, 8'hFF);
    check("rst_segs", {1'b0, segs_n}, 8'h7F);
    check("rst_dp", {7'd0, dp_n}, 8'h01);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) tick();

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(1, 40)) tick();
      send(($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 11)) : 4'd0,
           ($urandom_range(0, 2) != 0) ? 4'($urandom_range(0, 11)) : 4'd0,
           4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (70) tick();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
